fir_coeff_loader: RTL and testbench

Initiator side of the FIR block's coefficient-load protocol, which is asserting s_set_coeffs with tvalid low and presenting one coefficient byte per cycle.
- Sits in front of FIR and owns its x_n / s_axis_fir_tvalid / s_set_coeffs inputs.
- In normal operation it passes the sample stream through with one register stage.
- It collects coefficient bytes from a simple valid/ready config port. Once a full set is held, it launches the load sequence, then flushes with zeros.

---
 rtl/fir_coeff_loader_pkg.sv | 25 ++
 rtl/fir_coeff_shadow.sv | 58 +++++
 rtl/fir_coeff_loader.sv | 195 +++++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_loader_pkg.sv
// rtl/fir_coeff_loader_pkg.sv - shared parameters and state type for the FIR coefficient loader
//
// Purpose: default widths and counts for the loader, the FSM state encoding,
//          and a helper that sizes index counters.
// Ports:   none (package).

package fir_coeff_loader_pkg;

  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned NUM_COEFFS_DEF   = 3;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned DROP_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_shadow.sv
// rtl/fir_coeff_shadow.sv - coefficient byte capture and shadow storage
//
// Purpose: collects coefficient bytes into a shadow array, tracks how many
//          have been taken, and offers an indexed read for the load sequence.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   i_wr_en         store i_byte at the current fill position (already
//                   qualified by the caller: idle, valid, not clearing)
//   i_clear         discard the partially collected set
//   i_byte          coefficient byte to store
//   i_rd_idx        shadow entry to present on o_rd_data
//   o_rd_data       shadow[i_rd_idx]
//   o_last_slot     the next stored byte completes the set

module fir_coeff_shadow
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_COEFFS = NUM_COEFFS_DEF,
  localparam int unsigned IDX_W     = idx_width(NUM_COEFFS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_byte,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_last_slot
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  logic [DATA_W-1:0] r_shadow [NUM_COEFFS];
  logic [IDX_W-1:0]  r_byte_cnt;
  logic              w_last;

  assign w_last      = (r_byte_cnt == LAST_IDX);
  assign o_last_slot = w_last;
  assign o_rd_data   = r_shadow[i_rd_idx];

  // Completing a set wraps the fill position to 0 so the loader comes back
  // to IDLE ready for a fresh set; the stored bytes stay until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_wr_en) begin
      r_shadow[r_byte_cnt] <= i_byte;
      r_byte_cnt           <= w_last ? '0 : r_byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - FIR sample pass-through and coefficient-load initiator
//
// Purpose: registers the sample stream into the FIR; once a full coefficient
//          set has been collected it drives the load sequence (s_set_coeffs
//          high, tvalid low, one byte per cycle) followed by zero flush cycles.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   i_sample          signed input sample
//   i_sample_valid    sample qualifier
//   i_cfg_byte        coefficient byte
//   i_cfg_valid       coefficient byte valid
//   o_cfg_ready       byte accepted when valid && ready (high in IDLE)
//   i_cfg_clear       discard a partially collected set (IDLE only)
//   o_x_n             to FIR x_n
//   o_fir_tvalid      to FIR s_axis_fir_tvalid
//   o_set_coeffs      to FIR s_set_coeffs
//   o_busy            high in LOAD or FLUSH
//   o_load_done       one-cycle pulse on the first IDLE cycle after FLUSH
//   o_drop_cnt        saturating count of samples dropped while busy

module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned NUM_COEFFS   = NUM_COEFFS_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned DROP_W       = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_cfg_byte,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic              i_cfg_clear,
  output logic [DATA_W-1:0] o_x_n,
  output logic              o_fir_tvalid,
  output logic              o_set_coeffs,
  output logic              o_busy,
  output logic              o_load_done,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int unsigned      IDX_W  = idx_width(NUM_COEFFS);
  localparam int unsigned      FL_W   = idx_width(FLUSH_CYCLES);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_COEFFS - 1);
  localparam logic [FL_W-1:0]  LAST_F = FL_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t            r_state;
  logic [IDX_W-1:0]  r_k;
  logic [FL_W-1:0]   r_fcnt;
  logic [DATA_W-1:0] r_x_n;
  logic              r_fir_tvalid;
  logic              r_set_coeffs;
  logic              r_load_done;
  logic [DROP_W-1:0] r_drop_cnt;

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_k_nxt;
  logic [FL_W-1:0]   w_fcnt_nxt;
  logic [DATA_W-1:0] w_x_n_nxt;
  logic              w_tvalid_nxt;
  logic              w_set_nxt;
  logic              w_done_nxt;

  logic              w_idle;
  logic              w_wr_en;
  logic              w_clear;
  logic              w_last_slot;
  logic              w_launch;
  logic              w_drop_evt;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;

  assign w_idle   = (r_state == IDLE);
  assign w_clear  = w_idle && i_cfg_clear;
  assign w_wr_en  = w_idle && i_cfg_valid && !i_cfg_clear;
  assign w_launch = w_wr_en && w_last_slot;

  // A sample arriving while busy, or in the launch cycle itself, cannot
  // reach the FIR because the x_n path is owned by the load sequence.
  assign w_drop_evt = i_sample_valid && (!w_idle || w_launch);

  // Look one entry ahead: the registered x_n for the next LOAD cycle is
  // fetched during the current one. IDLE reads entry 0 for the launch.
  assign w_rd_idx = (r_state == LOAD && r_k != LAST_K) ? r_k + 1'b1 : '0;

  assign o_cfg_ready  = w_idle;
  assign o_busy       = !w_idle;
  assign o_x_n        = r_x_n;
  assign o_fir_tvalid = r_fir_tvalid;
  assign o_set_coeffs = r_set_coeffs;
  assign o_load_done  = r_load_done;
  assign o_drop_cnt   = r_drop_cnt;

  fir_coeff_shadow #(
    .DATA_W     (DATA_W),
    .NUM_COEFFS (NUM_COEFFS)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_en),
    .i_clear     (w_clear),
    .i_byte      (i_cfg_byte),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data   (w_rd_data),
    .o_last_slot (w_last_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_fcnt       <= '0;
      r_x_n        <= '0;
      r_fir_tvalid <= 1'b0;
      r_set_coeffs <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_x_n        <= w_x_n_nxt;
      r_fir_tvalid <= w_tvalid_nxt;
      r_set_coeffs <= w_set_nxt;
      r_load_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_fcnt_nxt   = r_fcnt;
    w_x_n_nxt    = '0;
    w_tvalid_nxt = 1'b0;
    w_set_nxt    = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt = LOAD;
          w_k_nxt     = '0;
          w_set_nxt   = 1'b1;
          // With a single coefficient the byte being accepted is entry 0
          // and is not yet in the shadow array.
          w_x_n_nxt   = (NUM_COEFFS == 1) ? i_cfg_byte : w_rd_data;
        end else begin
          w_x_n_nxt    = i_sample;
          w_tvalid_nxt = i_sample_valid;
        end
      end

      LOAD: begin
        if (r_k == LAST_K) begin
          w_fcnt_nxt = '0;
          if (FLUSH_CYCLES == 0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = FLUSH;
          end
        end else begin
          w_k_nxt   = r_k + 1'b1;
          w_set_nxt = 1'b1;
          w_x_n_nxt = w_rd_data;
        end
      end

      FLUSH: begin
        if (r_fcnt == LAST_F) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_fcnt_nxt = r_fcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Diagnostic only: counts until reset and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop_evt && r_drop_cnt != {DROP_W{1'b1}}) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - self-checking bench for fir_coeff_loader

module tb_fir_coeff_loader;

  localparam int DATA_W       = 8;
  localparam int NUM_COEFFS   = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int DROP_W       = 8;
  localparam int DROP_MAX     = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] i_sample = '0;
  logic              i_sample_valid = 1'b0;
  logic [DATA_W-1:0] i_cfg_byte = '0;
  logic              i_cfg_valid = 1'b0;
  logic              i_cfg_clear = 1'b0;
  logic              o_cfg_ready;
  logic [DATA_W-1:0] o_x_n;
  logic              o_fir_tvalid;
  logic              o_set_coeffs;
  logic              o_busy;
  logic              o_load_done;
  logic [DROP_W-1:0] o_drop_cnt;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .DATA_W       (DATA_W),
    .NUM_COEFFS   (NUM_COEFFS),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .DROP_W       (DROP_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .i_cfg_byte     (i_cfg_byte),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_clear    (i_cfg_clear),
    .o_x_n          (o_x_n),
    .o_fir_tvalid   (o_fir_tvalid),
    .o_set_coeffs   (o_set_coeffs),
    .o_busy         (o_busy),
    .o_load_done    (o_load_done),
    .o_drop_cnt     (o_drop_cnt)
  );

  // FIR-facing view: {x_n, tvalid, set_coeffs, load_done}
  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic              tv;
    logic              sc;
    logic              done;
  } out_t;

  // Reference model: bytes gathered so far, and the scripted outputs still
  // owed by an in-progress load (busy while this script is non-empty).
  logic [DATA_W-1:0] pend[$];
  out_t              script[$];
  out_t              exp_o;
  int                exp_drop;

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_reset();
    pend.delete();
    script.delete();
    exp_o    = '0;
    exp_drop = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit drop = 1'b0;
    if (script.size() != 0) begin
      exp_o = script.pop_front();
      drop  = i_sample_valid;
    end else if (i_cfg_clear) begin
      pend.delete();
      exp_o = {i_sample, i_sample_valid, 1'b0, 1'b0};
    end else begin
      if (i_cfg_valid) pend.push_back(i_cfg_byte);
      if (pend.size() == NUM_COEFFS) begin
        exp_o = {pend[0], 1'b0, 1'b1, 1'b0};
        for (int i = 1; i < NUM_COEFFS; i++) script.push_back({pend[i], 1'b0, 1'b1, 1'b0});
        repeat (FLUSH_CYCLES) script.push_back({8'h00, 1'b0, 1'b0, 1'b0});
        script.push_back({8'h00, 1'b0, 1'b0, 1'b1});
        pend.delete();
        drop = i_sample_valid;
      end else begin
        exp_o = {i_sample, i_sample_valid, 1'b0, 1'b0};
      end
    end
    if (drop && exp_drop < DROP_MAX) exp_drop++;
  endtask

  task automatic check(input string tag);
    out_t obs;
    logic exp_rdy;
    obs     = {o_x_n, o_fir_tvalid, o_set_coeffs, o_load_done};
    exp_rdy = (script.size() == 0);
    vectors++;
    assert (obs === exp_o) else begin
      miscompares++;
      $error("FAIL %s fir_out observed=%h expected=%h", tag, obs, exp_o);
    end
    vectors++;
    assert ({o_cfg_ready, o_busy} === {exp_rdy, ~exp_rdy}) else begin
      miscompares++;
      $error("FAIL %s ready_busy observed=%b%b expected=%b%b", tag, o_cfg_ready, o_busy, exp_rdy, ~exp_rdy);
    end
    vectors++;
    assert (o_drop_cnt === 8'(exp_drop)) else begin
      miscompares++;
      $error("FAIL %s drop_cnt observed=%0d expected=%0d", tag, o_drop_cnt, exp_drop);
    end
  endtask

  task automatic chk_direct(input string tag, input logic [DATA_W-1:0] x,
                            input logic tv, input logic sc, input logic done);
    vectors++;
    assert ({o_x_n, o_fir_tvalid, o_set_coeffs, o_load_done} === {x, tv, sc, done}) else begin
      miscompares++;
      $error("FAIL %s direct observed=%h/%b/%b/%b expected=%h/%b/%b/%b", tag,
             o_x_n, o_fir_tvalid, o_set_coeffs, o_load_done, x, tv, sc, done);
    end
  endtask

  task automatic chk_drop(input string tag, input int val);
    vectors++;
    assert (o_drop_cnt === 8'(val)) else begin
      miscompares++;
      $error("FAIL %s drop_direct observed=%0d expected=%0d", tag, o_drop_cnt, val);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic cfg(input logic [DATA_W-1:0] b, input string tag);
    i_cfg_valid = 1'b1;
    i_cfg_byte  = b;
    step(tag);
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset: everything zero, ready high, asynchronously.
    model_reset();
    #1;
    check("reset_t0");
    chk_direct("reset_t0", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold");
    end
    rst_n = 1'b1;

    // Pass-through with one cycle of latency; x_n follows even when invalid.
    i_sample = 8'd1;  i_sample_valid = 1'b1;
    step("pass_valid");
    chk_direct("pass_valid", 8'd1, 1'b1, 1'b0, 1'b0);
    i_sample = 8'h22; i_sample_valid = 1'b0;
    step("pass_invalid");
    chk_direct("pass_invalid", 8'h22, 1'b0, 1'b0, 1'b0);

    // Basic load of 1,2,3 then two flush cycles and a done pulse.
    cfg(8'd1, "load_b1");
    cfg(8'd2, "load_b2");
    cfg(8'd3, "load_b3");
    chk_direct("load_k0", 8'd1, 1'b0, 1'b1, 1'b0);
    step("load_k1");  chk_direct("load_k1", 8'd2, 1'b0, 1'b1, 1'b0);
    step("load_k2");  chk_direct("load_k2", 8'd3, 1'b0, 1'b1, 1'b0);
    step("flush0");   chk_direct("flush0", 8'd0, 1'b0, 1'b0, 1'b0);
    step("flush1");   chk_direct("flush1", 8'd0, 1'b0, 1'b0, 1'b0);
    step("done");     chk_direct("done", 8'd0, 1'b0, 1'b0, 1'b1);
    step("after_done");

    // Samples held valid through config and load: launch + 5 busy drops.
    i_sample_valid = 1'b1;
    i_sample = 8'h40; cfg(8'd1, "drop_b1");
    i_sample = 8'h41; cfg(8'd2, "drop_b2");
    i_sample = 8'h42; cfg(8'd3, "drop_b3");
    for (int i = 0; i < NUM_COEFFS + FLUSH_CYCLES; i++) begin
      i_sample = 8'h50 + 8'(i);
      step("drop_busy");
    end
    chk_drop("drop_six", 6);
    i_sample = 8'h77;
    step("resume");
    chk_direct("resume", 8'h77, 1'b1, 1'b0, 1'b0);
    i_sample_valid = 1'b0;

    // Partial set cleared; a byte together with clear is discarded.
    cfg(8'd5, "clr_b5");
    cfg(8'd6, "clr_b6");
    i_cfg_clear = 1'b1;
    cfg(8'hEE, "clr_with_byte");
    i_cfg_clear = 1'b0;
    cfg(8'd7, "clr_b7");
    cfg(8'd8, "clr_b8");
    cfg(8'd9, "clr_b9");
    chk_direct("clr_k0", 8'd7, 1'b0, 1'b1, 1'b0);
    step("clr_k1");  chk_direct("clr_k1", 8'd8, 1'b0, 1'b1, 1'b0);
    step("clr_k2");  chk_direct("clr_k2", 8'd9, 1'b0, 1'b1, 1'b0);
    repeat (FLUSH_CYCLES + 1) step("clr_tail");

    // Reset during the second LOAD cycle, then a clean load.
    cfg(8'hA1, "rst_b1");
    cfg(8'hA2, "rst_b2");
    cfg(8'hA3, "rst_b3");
    step("rst_k1");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_load");
    chk_direct("rst_mid_load", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_mid_hold");
    rst_n = 1'b1;
    cfg(8'hB1, "post_b1");
    cfg(8'hB2, "post_b2");
    cfg(8'hB3, "post_b3");
    chk_direct("post_k0", 8'hB1, 1'b0, 1'b1, 1'b0);
    step("post_k1");  chk_direct("post_k1", 8'hB2, 1'b0, 1'b1, 1'b0);
    step("post_k2");  chk_direct("post_k2", 8'hB3, 1'b0, 1'b1, 1'b0);
    repeat (FLUSH_CYCLES + 1) step("post_tail");

    // Randomized mix of samples, config bytes and clears.
    for (int i = 0; i < 300; i++) begin
      i_sample       = 8'($urandom);
      i_sample_valid = 1'($urandom_range(0, 1));
      i_cfg_byte     = 8'($urandom);
      i_cfg_valid    = ($urandom_range(0, 2) == 0);
      i_cfg_clear    = ($urandom_range(0, 15) == 0);
      step("random");
    end
    i_cfg_valid = 1'b0;
    i_cfg_clear = 1'b0;

    // Saturation: continuous loads with samples always offered.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("sat_reset");
    rst_n = 1'b1;
    i_sample_valid = 1'b1;
    i_cfg_valid    = 1'b1;
    for (int i = 0; i < 400; i++) begin
      i_sample   = 8'($urandom);
      i_cfg_byte = 8'($urandom);
      step("saturate");
    end
    chk_drop("sat_255", DROP_MAX);
    i_cfg_valid    = 1'b0;
    i_sample_valid = 1'b0;
    repeat (8) step("sat_tail");
    chk_drop("sat_hold", DROP_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
